// File: rtl/enable_map.sv
// ============================================================================
// Module   : enable_map
// Brief    : Maps each bus access {config, rwbar, region} to chip-select enables
//            through a writable table that is cleared to a default after reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module enable_map #(
    parameter int ADDR_WIDTH       = 16,
    parameter int GRANULARITY_BITS = 8,
    parameter int CONFIG_BITS      = 5,
    parameter int NUM_CHANNELS     = 2,
    parameter logic [NUM_CHANNELS-1:0] DEFAULT_VAL = '0,
    localparam int REGION_BITS     = ADDR_WIDTH - GRANULARITY_BITS,
    localparam int TABLE_ADDR_BITS = CONFIG_BITS + 1 + REGION_BITS
) (
    input  logic                       fpga_clk,
    input  logic                       rst_n,
    input  logic [ADDR_WIDTH-1:0]      address,
    input  logic                       phi2,
    input  logic                       rwbar,
    input  logic [CONFIG_BITS-1:0]     configuration,
    input  logic                       config_load,
    input  logic                       table_we,
    input  logic [TABLE_ADDR_BITS-1:0] table_write_addr,
    input  logic [NUM_CHANNELS-1:0]    table_val,
    output logic                       table_ready,
    output logic [NUM_CHANNELS-1:0]    cs,
    output logic                       we,
    output logic [CONFIG_BITS-1:0]     active_config
);

    localparam int DEPTH = 1 << TABLE_ADDR_BITS;
    localparam logic [TABLE_ADDR_BITS:0] CLEAR_LAST = (TABLE_ADDR_BITS+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LATCH = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                       state;
    logic [TABLE_ADDR_BITS:0]     clear_cnt;
    logic [NUM_CHANNELS-1:0]      outval;
    logic [CONFIG_BITS-1:0]       config_reg;
    logic [NUM_CHANNELS-1:0]      table_mem [DEPTH];

    logic [TABLE_ADDR_BITS-1:0]   lookup_idx;
    logic                         mem_wen;
    logic [TABLE_ADDR_BITS-1:0]   mem_waddr;
    logic [NUM_CHANNELS-1:0]      mem_wdata;
    logic                         unused_addr_low;

    // Region offset bits never take part in the lookup.
    assign unused_addr_low = ^address[GRANULARITY_BITS-1:0];
    assign lookup_idx      = {config_reg, rwbar, address[ADDR_WIDTH-1 -: REGION_BITS]};

    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = table_write_addr;
        mem_wdata = table_val;
        if (state == S_CLEAR) begin
            mem_wen   = 1'b1;
            mem_waddr = clear_cnt[TABLE_ADDR_BITS-1:0];
            mem_wdata = DEFAULT_VAL;
        end else if (state == S_RUN && table_we) begin
            mem_wen = 1'b1;
        end
    end

    // Table storage carries no reset so it can map onto block RAM.
    always_ff @(posedge fpga_clk) begin
        if (mem_wen) begin
            table_mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge fpga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clear_cnt  <= '0;
            outval     <= '0;
            config_reg <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    outval    <= '0;
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == CLEAR_LAST) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    config_reg <= configuration;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    // Single-port table: a write cycle skips the lookup.
                    if (!table_we) begin
                        outval <= table_mem[lookup_idx];
                    end
                    if (config_load) begin
                        config_reg <= configuration;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    assign table_ready   = (state == S_RUN);
    assign cs            = {NUM_CHANNELS{phi2}} & outval;
    assign we            = phi2 & ~rwbar;
    assign active_config = config_reg;

endmodule

`default_nettype wire

// File: tb/tb_enable_map.sv
// ============================================================================
// Module   : tb_enable_map
// Brief    : Directed self-checking bench for enable_map (DEPTH = 128 setup).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_enable_map;

    logic       fpga_clk = 1'b0;
    logic       rst_n;
    logic [15:0] address;
    logic       phi2;
    logic       rwbar;
    logic [1:0] configuration;
    logic       config_load;
    logic       table_we;
    logic [6:0] table_write_addr;
    logic [1:0] table_val;
    logic       table_ready;
    logic [1:0] cs;
    logic       we;
    logic [1:0] active_config;

    int checks = 0;
    int errors = 0;
    int cycles;

    enable_map #(
        .ADDR_WIDTH      (16),
        .GRANULARITY_BITS(12),
        .CONFIG_BITS     (2),
        .NUM_CHANNELS    (2),
        .DEFAULT_VAL     (2'b01)
    ) dut (
        .fpga_clk        (fpga_clk),
        .rst_n           (rst_n),
        .address         (address),
        .phi2            (phi2),
        .rwbar           (rwbar),
        .configuration   (configuration),
        .config_load     (config_load),
        .table_we        (table_we),
        .table_write_addr(table_write_addr),
        .table_val       (table_val),
        .table_ready     (table_ready),
        .cs              (cs),
        .we              (we),
        .active_config   (active_config)
    );

    always #5 fpga_clk = ~fpga_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    // Counts edges from release until table_ready; pulses a write at cycle 10.
    task automatic run_clear(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            table_we = (i == 10);
            step(1);
            n = i;
            if (table_ready) break;
        end
        table_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; address = 16'h0000; phi2 = 1'b1; rwbar = 1'b1;
        configuration = 2'd2; config_load = 1'b0; table_we = 1'b0;
        table_write_addr = 7'h55; table_val = 2'b11;
        step(2);
        chk("reset_cs", cs, 2'b00);
        chk("reset_ready", table_ready, 1'b0);
        chk("reset_cfg", active_config, 2'd0);

        // Abort the clear at clear_cnt = 50.
        rst_n = 1'b1;
        step(50);
        chk("midclear_ready", table_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midclear_rst_cs", cs, 2'b00);
        chk("midclear_rst_ready", table_ready, 1'b0);
        step(1);
        rst_n = 1'b1;
        run_clear(cycles);
        chk("clear_cycles", cycles, 129);
        chk("latched_cfg", active_config, 2'd2);

        step(1);
        chk("default_cs", cs, 2'b01);
        address = 16'h5000;
        step(1);
        chk("clear_write_ignored", cs, 2'b01);

        // Write {2,1,C} = 10; outval holds during the write cycle.
        table_we = 1'b1; table_write_addr = 7'h5C; table_val = 2'b10;
        address = 16'hC123;
        step(1);
        chk("write_hold", cs, 2'b01);
        table_we = 1'b0;
        step(1);
        chk("read_written", cs, 2'b10);
        rwbar = 1'b0;
        step(1);
        chk("write_side_cs", cs, 2'b01);
        chk("we_high", we, 1'b1);

        // Writes stall the lookup while the address moves.
        rwbar = 1'b1;
        step(1);
        chk("prior_value", cs, 2'b10);
        table_we = 1'b1; table_write_addr = 7'h53; table_val = 2'b11;
        address = 16'h0000;
        step(2);
        chk("stall_hold", cs, 2'b10);
        table_we = 1'b0;
        step(1);
        chk("stall_release", cs, 2'b01);
        address = 16'h3000;
        step(1);
        chk("second_write", cs, 2'b11);

        // Configuration changes only take effect through config_load.
        address = 16'hC000; configuration = 2'd3;
        step(1);
        chk("cfg_unlatched_cs", cs, 2'b10);
        chk("cfg_unlatched", active_config, 2'd2);
        config_load = 1'b1;
        step(1);
        config_load = 1'b0;
        chk("cfg_loaded", active_config, 2'd3);
        chk("cfg_old_lookup", cs, 2'b10);
        step(1);
        chk("cfg_new_lookup", cs, 2'b01);

        // Reset during RUN wipes earlier writes.
        rst_n = 1'b0;
        #1;
        chk("run_rst_cs", cs, 2'b00);
        chk("run_rst_ready", table_ready, 1'b0);
        chk("run_rst_cfg", active_config, 2'd0);
        configuration = 2'd2;
        step(1);
        rst_n = 1'b1;
        run_clear(cycles);
        chk("reclear_cycles", cycles, 129);
        step(1);
        chk("rewritten_default", cs, 2'b01);
        address = 16'h3000;
        step(1);
        chk("rewritten_default2", cs, 2'b01);

        // phi2 low gates everything.
        rwbar = 1'b0; phi2 = 1'b0;
        #1;
        chk("phi2_low_cs", cs, 2'b00);
        chk("phi2_low_we", we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/enable_map.md
Name: enable_map

Overview:
Parametrised successor to the ROM/RAM enable lookup. It maps each bus access (configuration, read/write, address region) to NUM_CHANNELS chip-select enables through a writable on-chip table. New in this generation:
- Reset-time table clear to a known default.
- Configuration latched explicitly instead of sampled live.
- A ready-qualified table write port.
It sits between the 6502-side bus (address, phi2, rwbar) and the RAM/bus/ROM chip-select fabric, clocked by fpga_clk.

Parameters:
ADDR_WIDTH, 16, CPU address width.
GRANULARITY_BITS, 8, log2 of the region size; each 2^GRANULARITY_BITS-byte region has its own entry.
CONFIG_BITS, 5, width of the configuration selector.
NUM_CHANNELS, 2, enable bits per entry (bit i drives cs[i]).
DEFAULT_VAL, 0, NUM_CHANNELS-bit value written to every entry during clear.
Derived: REGION_BITS = ADDR_WIDTH-GRANULARITY_BITS; TABLE_ADDR_BITS = CONFIG_BITS+1+REGION_BITS; DEPTH = 2^TABLE_ADDR_BITS.

Ports:
fpga_clk  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
address  in  ADDR_WIDTH  CPU address
phi2  in  1  CPU phase-2 clock (qualifier)
rwbar  in  1  CPU read(1)/write(0)
configuration  in  CONFIG_BITS  requested configuration
config_load  in  1  strobe: re-latch configuration while in RUN
table_we  in  1  table write request
table_write_addr  in  TABLE_ADDR_BITS  entry index {config, rwbar, region}
table_val  in  NUM_CHANNELS  entry data
table_ready  out  1  high only in RUN; writes accepted only when high
cs  out  NUM_CHANNELS  phi2 & entry bit per channel
we  out  1  phi2 & ~rwbar
active_config  out  CONFIG_BITS  currently latched configuration

Behaviour:
- Lookup index = {config_reg, rwbar, address[ADDR_WIDTH-1 -: REGION_BITS]}. The live configuration input is never used for lookup.
- Reset (rst_n low): state=CLEAR, clear_cnt=0, outval=0, config_reg=0, table_ready=0. cs=0 regardless of phi2. Table contents are undefined until the clear completes.
- CLEAR state:
  - Each cycle, table[clear_cnt] <= DEFAULT_VAL and clear_cnt increments.
  - When clear_cnt=DEPTH-1 is written, go to LATCH. CLEAR lasts exactly DEPTH cycles.
  - outval is held at 0; table_we and config_load are ignored.
- LATCH state: for one cycle, config_reg <= configuration, then go to RUN.
- RUN state: table_ready=1. Each cycle:
  - If table_we=1: table[table_write_addr] <= table_val; outval holds its previous value (single-port, write priority).
  - Else: outval <= table[lookup index]. Latency is 1 fpga_clk from address/rwbar stable to outval.
  - config_load=1: config_reg <= configuration at that edge. The lookup in the same cycle uses the old config_reg; the next cycle's lookup uses the new value. This is independent of table_we (both may occur in one cycle).
- cs and we are combinational from phi2 and registered state: cs = {NUM_CHANNELS{phi2}} & outval; we = phi2 & ~rwbar. we is not gated by state.
- A write to the entry currently being looked up becomes visible on the first non-write cycle after it.
- rst_n asserted mid-CLEAR or mid-RUN aborts immediately. The clear restarts from 0 on release, and previously written entries are overwritten with DEFAULT_VAL.
- clear_cnt is TABLE_ADDR_BITS+1 wide; there is no wrap-around in CLEAR.
- active_config = config_reg.

Test Plan:
Parameters for all scenarios: GRANULARITY_BITS=12, CONFIG_BITS=2, NUM_CHANNELS=2, DEFAULT_VAL=2'b01, so DEPTH=128.
1. Release rst_n with configuration=2 -> table_ready rises exactly 129 cycles after release (128 CLEAR + 1 LATCH). active_config=2. With phi2=1, any address gives cs=2'b01.
2. In RUN, write table[{2'd2,1'b1,4'hC}]=2'b10, then read address 16'hC123, rwbar=1, phi2=1 -> cs=2'b10 one cycle later. Same address with rwbar=0 -> cs=2'b01 and we=1.
3. Hold table_we=1 to another entry while the address changes -> cs holds its prior value. It updates on the first cycle with table_we=0.
4. Change configuration 2->3 without config_load -> cs unchanged. Pulse config_load -> active_config=3 next cycle, and the lookup uses config 3 the cycle after.
5. Assert rst_n low at clear_cnt=50 and during RUN after writes -> outputs 0 and table_ready=0 immediately. After release, the full 128-cycle clear repeats, and the entry written earlier reads back DEFAULT_VAL.
6. table_we pulsed during CLEAR -> ignored; the entry reads DEFAULT_VAL in RUN. phi2=0 at any time -> cs=0 and we=0.
